// File: rtl/adder_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared W-bit combinational adder.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module adder_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int W       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] opA,
    input  logic [NUM_REQ*W-1:0] opB,
    output logic [W-1:0]         addA,
    output logic [W-1:0]         addB,
    input  logic [W-1:0]         addSum,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [W-1:0]         result,
    output logic                 busy
);

    // state | meaning
    // IDLE  | waiting for any req; winner latched on exit
    // EXEC  | operands stable on adder; sum captured at end
    // RESP  | done pulses to the owner; pointer advances at end

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win_idx;
    logic [IW:0]   cand;
    logic          found;

    // Rotating scan starting at rr_ptr; first requesting index wins.
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
            if (!found && req[cand[IW-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addA   <= '0;
            addB   <= '0;
            grant  <= '0;
            done   <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        addA  <= opA[int'(win_idx)*W +: W];
                        addB  <= opB[int'(win_idx)*W +: W];
                        grant <= NUM_REQ'(1) << win_idx;
                    end
                end
                EXEC: begin
                    result <= addSum;
                    done   <= grant;
                end
                RESP: begin
                    done  <= '0;
                    grant <= '0;
                end
                default: begin
                    done  <= '0;
                    grant <= '0;
                end
            endcase
        end
    end

`ifdef ADDER_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IW-1:0] owner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            if (state == IDLE && (|req)) owner <= win_idx;
            if (state == RESP)
                rr_ptr <= (owner == IW'(NUM_REQ-1)) ? '0 : owner + 1'b1;
        end
    end
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter with a behavioural arbitration model.
// Honours ADDER_ARB_FIXED_PRIO_EN the same way as the design.
module tb_adder_arbiter;
    localparam int N = 3;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] opA, opB;
    logic [W-1:0]   addA, addB, addSum;
    logic [N-1:0]   grant, done;
    logic [W-1:0]   result;
    logic           busy;

    logic [W-1:0] a_op [N];
    logic [W-1:0] b_op [N];

    int total = 0;
    int bad   = 0;
    int m_rr  = 0;
    int last_w;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign opA[g*W +: W] = a_op[g];
        assign opB[g*W +: W] = b_op[g];
    end

    // The shared adder itself.
    assign addSum = addA + addB;

    adder_arbiter #(.NUM_REQ(N), .W(W)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .opA(opA), .opB(opB),
        .addA(addA), .addB(addB), .addSum(addSum), .grant(grant),
        .done(done), .result(result), .busy(busy)
    );

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic void advance(input int w);
`ifdef ADDER_ARB_FIXED_PRIO_EN
        m_rr = 0;
`else
        m_rr = (w + 1) % N;
`endif
    endfunction

    function automatic logic [W-1:0] wsum(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned s;
        s = (int'(a) + int'(b)) % (1 << W);
        return W'(s);
    endfunction

    task automatic apply_reset();
        req = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        m_rr = 0;
        @(posedge clk); #1;
    endtask

    // Drives one request set, follows the winner through IDLE->EXEC->RESP->IDLE.
    task automatic run_op(input logic [N-1:0] r, input bit rearm, input string tag);
        int w;
        logic [W-1:0] ea, eb;
        req = r;
        w = pick(r);
        ea = a_op[w];
        eb = b_op[w];
        last_w = w;
        @(posedge clk); #1;
        total++;
        if (grant !== N'(1 << w) || addA !== ea || addB !== eb || busy !== 1'b1 || done !== '0) begin
            bad++;
            $display("FAIL %s grant: got g=%b a=%h b=%h busy=%b d=%b want g=%b a=%h b=%h busy=1 d=0",
                     tag, grant, addA, addB, busy, done, N'(1 << w), ea, eb);
        end
        @(posedge clk); #1;
        total++;
        if (done !== N'(1 << w) || result !== wsum(ea, eb) || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s done: got d=%b res=%h busy=%b want d=%b res=%h busy=1",
                     tag, done, result, busy, N'(1 << w), wsum(ea, eb));
        end
        req[w] = 1'b0;
        @(posedge clk); #1;
        total++;
        if (done !== '0 || grant !== '0 || busy !== 1'b0 || result !== wsum(ea, eb)) begin
            bad++;
            $display("FAIL %s idle: got d=%b g=%b busy=%b res=%h want d=0 g=0 busy=0 res=%h",
                     tag, done, grant, busy, result, wsum(ea, eb));
        end
        if (rearm) req[w] = 1'b1;
        advance(w);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) begin a_op[i] = '0; b_op[i] = '0; end
        #2 reset_n = 1'b0;
        #2;
        total++;
        if (addA !== '0 || addB !== '0 || grant !== '0 || done !== '0 || result !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: got a=%h b=%h g=%b d=%b res=%h busy=%b want all 0",
                     addA, addB, grant, done, result, busy);
        end
        apply_reset();
    endtask

    task automatic test_single();
        a_op[0] = 16'h1234; b_op[0] = 16'h0102;
        run_op(3'b001, 1'b0, "single");
        total++;
        if (result !== 16'h1336) begin
            bad++;
            $display("FAIL single_value: got %h want 1336", result);
        end
    endtask

    task automatic test_wrap();
        a_op[1] = 16'hFFFF; b_op[1] = 16'h0001;
        run_op(3'b010, 1'b0, "wrap");
        total++;
        if (result !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_value: got %h want 0000", result);
        end
    endtask

    task automatic test_operand_change();
        a_op[2] = 16'h0010; b_op[2] = 16'h0020;
        req = 3'b100;
        @(posedge clk); #1;
        a_op[2] = 16'h7000;
        @(posedge clk); #1;
        total++;
        if (result !== 16'h0030 || done !== 3'b100) begin
            bad++;
            $display("FAIL opchange: got res=%h d=%b want res=0030 d=100", result, done);
        end
        req = '0;
        @(posedge clk); #1;
        advance(2);
    endtask

    task automatic test_withdraw();
        int pulses;
        int w;
        a_op[1] = 16'h0A0A; b_op[1] = 16'h0505;
        w = pick(3'b010);
        req = 3'b010;
        @(posedge clk); #1;
        req = '0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (done[1]) pulses++;
            if (c == 0) begin
                total++;
                if (done !== '0 || grant !== 3'b010) begin
                    bad++;
                    $display("FAIL withdraw_exec: got d=%b g=%b want d=000 g=010", done, grant);
                end
            end
            if (c >= 2) begin
                total++;
                if (grant !== '0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL withdraw_regrant: cycle %0d got g=%b busy=%b want 0", c, grant, busy);
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (pulses != 1 || result !== 16'h0F0F) begin
            bad++;
            $display("FAIL withdraw_done: got pulses=%0d res=%h want 1 and 0f0f", pulses, result);
        end
        advance(w);
    endtask

    task automatic test_reset_midop();
        int w;
        a_op[0] = 16'h1111; b_op[0] = 16'h2222;
        req = 3'b001;
        @(posedge clk); #1;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (grant !== '0 || done !== '0 || result !== '0 || addA !== '0 || addB !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_midop: got g=%b d=%b res=%h a=%h b=%h busy=%b want all 0",
                     grant, done, result, addA, addB, busy);
        end
        req = '0;
        #2 reset_n = 1'b1;
        m_rr = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            total++;
            if (done !== '0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_quiet: cycle %0d got d=%b busy=%b want 0", c, done, busy);
            end
        end
        a_op[1] = 16'h0100; b_op[1] = 16'h0200;
        a_op[2] = 16'h0300; b_op[2] = 16'h0400;
        run_op(3'b110, 1'b0, "post_reset");
        w = last_w;
        total++;
        if (w != 1) begin
            bad++;
            $display("FAIL post_reset_ptr: got winner %0d want 1", w);
        end
    endtask

    task automatic test_back_to_back();
        int exp_order [4];
        apply_reset();
        for (int i = 0; i < N; i++) begin
            a_op[i] = W'(16'h1000 * (i + 1) + i);
            b_op[i] = W'(16'h0011 * (i + 3));
        end
`ifdef ADDER_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 0};
`endif
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            run_op(req, 1'b1, "b2b");
            total++;
            if (last_w != exp_order[k]) begin
                bad++;
                $display("FAIL b2b_order: op %0d got winner %0d want %0d", k, last_w, exp_order[k]);
            end
        end
        req = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < N; i++) begin
                a_op[i] = W'($urandom);
                b_op[i] = W'($urandom);
            end
            r = N'($urandom_range(1, (1 << N) - 1));
            run_op(r, 1'b0, "random");
            req = '0;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_operand_change();
        test_withdraw();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end
endmodule
